// File: rtl/cp0_pkg.sv
// Shared constants for the extended coprocessor 0: register indices, exception codes
// and Status/Cause field positions.
package cp0_pkg;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_SR      = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;
  localparam logic [4:0] CP0_PRID    = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int unsigned SR_IE         = 0;
  localparam int unsigned SR_EXL        = 1;
  localparam int unsigned SR_IM_LSB     = 8;
  localparam int unsigned CAUSE_EXC_LSB = 2;
  localparam int unsigned CAUSE_IP_LSB  = 8;
  localparam int unsigned CAUSE_TI      = 30;
  localparam int unsigned CAUSE_BD      = 31;

  // A delay-slot fault restarts at the branch, one word earlier.
  function automatic logic [31:0] epc_align(input logic [31:0] pc, input logic bd);
    return (bd ? pc - 32'd4 : pc) & ~32'd3;
  endfunction

endpackage

// File: rtl/cp0_ext_if.sv
// Pipeline-side connection of coprocessor 0: register access, exception info and redirect.
interface cp0_ext_if #(
  parameter int unsigned HW_INT_N = 6
);
  logic [4:0]          A1;
  logic [31:0]         RD;
  logic [4:0]          A2;
  logic [31:0]         WD;
  logic                WE;
  logic [31:0]         nEPC;
  logic [4:0]          nExc;
  logic                nBD;
  logic [HW_INT_N-1:0] HWInt;
  logic                ERET;
  logic                IntReq;
  logic [31:0]         EPC;

  modport master (
    output A1, A2, WD, WE, nEPC, nExc, nBD, HWInt, ERET,
    input  RD, IntReq, EPC
  );

  modport slave (
    input  A1, A2, WD, WE, nEPC, nExc, nBD, HWInt, ERET,
    output RD, IntReq, EPC
  );
endinterface

// File: rtl/cp0_timer.sv
// Free-running Count with a Compare match that latches TI until Compare is rewritten.
module cp0_timer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        count_we_i,
  input  logic        compare_we_i,
  input  logic [31:0] wd_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        ti_o
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        ti_q, ti_d;

  always_comb begin
    count_d   = count_we_i ? wd_i : count_q + 32'd1;
    compare_d = compare_we_i ? wd_i : compare_q;
    ti_d      = ti_q;
    if (compare_we_i) begin
      ti_d = 1'b0;
    end else if (count_q == compare_q) begin
      ti_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q   <= 32'd0;
      compare_q <= 32'd0;
      ti_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_ext.sv
// Coprocessor 0 beside the MEM/WB boundary: interrupt/exception arbitration, EPC capture,
// mtc0/eret handling and optional Count/Compare timer.
module cp0_ext #(
  parameter int unsigned HW_INT_N = 6,
  parameter bit          TIMER_EN = 1'b1,
  parameter logic [31:0] PRID     = 32'h2020_1207
) (
  input logic       clk,
  input logic       reset,
  cp0_ext_if.slave  bus
);
  import cp0_pkg::*;

  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [7:0]  ip_q, ip_d;
  logic [4:0]  exc_q, exc_d;
  logic [31:0] epc_q, epc_d;

  logic [5:0]  hw_ext;
  logic        int_pend, exc_pend, int_req, wr_en;
  logic        ti;
  logic [31:0] count, compare;
  logic [31:0] rd;

  always_comb begin
    hw_ext                 = '0;
    hw_ext[HW_INT_N-1:0]   = bus.HWInt;
  end

  always_comb begin
    int_pend = ie_q & ~exl_q & (|(ip_q & im_q));
    exc_pend = (bus.nExc != EXC_INT) & ~exl_q;
    int_req  = (int_pend | exc_pend) & ~bus.ERET & ~reset;
    // Taking an exception squashes the mtc0 committing alongside it.
    wr_en    = bus.WE & ~int_req;
  end

  always_comb begin
    im_d  = im_q;
    exl_d = exl_q;
    ie_d  = ie_q;
    bd_d  = bd_q;
    exc_d = exc_q;
    epc_d = epc_q;
    ip_d  = {hw_ext[5] | ti, hw_ext[4:0], ip_q[1:0]};
    if (int_req) begin
      exl_d = 1'b1;
      exc_d = int_pend ? EXC_INT : bus.nExc;
      bd_d  = bus.nBD;
      epc_d = epc_align(bus.nEPC, bus.nBD);
    end else if (bus.WE) begin
      case (bus.A2)
        CP0_SR: begin
          im_d  = bus.WD[SR_IM_LSB +: 8];
          exl_d = bus.WD[SR_EXL];
          ie_d  = bus.WD[SR_IE];
        end
        CP0_CAUSE: ip_d[1:0] = bus.WD[CAUSE_IP_LSB +: 2];
        CP0_EPC:   epc_d     = bus.WD & ~32'd3;
        default: ;
      endcase
    end
    if (bus.ERET) begin
      exl_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im_q  <= 8'd0;
      exl_q <= 1'b0;
      ie_q  <= 1'b0;
      bd_q  <= 1'b0;
      ip_q  <= 8'd0;
      exc_q <= 5'd0;
      epc_q <= 32'd0;
    end else begin
      im_q  <= im_d;
      exl_q <= exl_d;
      ie_q  <= ie_d;
      bd_q  <= bd_d;
      ip_q  <= ip_d;
      exc_q <= exc_d;
      epc_q <= epc_d;
    end
  end

  if (TIMER_EN) begin : g_timer
    cp0_timer u_timer (
      .clk_i        (clk),
      .rst_i        (reset),
      .count_we_i   (wr_en && (bus.A2 == CP0_COUNT)),
      .compare_we_i (wr_en && (bus.A2 == CP0_COMPARE)),
      .wd_i         (bus.WD),
      .count_o      (count),
      .compare_o    (compare),
      .ti_o         (ti)
    );
  end else begin : g_no_timer
    assign count   = 32'd0;
    assign compare = 32'd0;
    assign ti      = 1'b0;
  end

  always_comb begin
    case (bus.A1)
      CP0_SR:      rd = {16'd0, im_q, 6'd0, exl_q, ie_q};
      CP0_CAUSE:   rd = {bd_q, ti, 14'd0, ip_q, 1'b0, exc_q, 2'b00};
      CP0_EPC:     rd = epc_q;
      CP0_PRID:    rd = PRID;
      CP0_COUNT:   rd = count;
      CP0_COMPARE: rd = compare;
      default:     rd = 32'd0;
    endcase
  end

  assign bus.RD     = rd;
  assign bus.IntReq = int_req;
  assign bus.EPC    = epc_q;

endmodule

// File: tb/tb_cp0_ext.sv
// Bench for cp0_ext: directed vector table, hand-built timer/reset sequences, then random
// traffic against a behavioural model of the coprocessor.
module tb_cp0_ext;

  logic clk = 1'b0;
  logic reset;

  cp0_ext_if #(.HW_INT_N(6)) bus ();

  cp0_ext #(
    .HW_INT_N (6),
    .TIMER_EN (1'b1),
    .PRID     (32'h2020_1207)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        we;
    logic [4:0]  a2;
    logic [31:0] wd;
    logic        eret;
    logic [4:0]  nexc;
    logic        nbd;
    logic [31:0] nepc;
    logic [5:0]  hwint;
    logic [4:0]  a1;
    logic        exp_int;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [23];

  // Behavioural model state.
  logic [7:0]  m_im, m_ip;
  logic        m_exl, m_ie, m_bd, m_ti;
  logic [4:0]  m_exc;
  logic [31:0] m_epc, m_count, m_compare;

  function automatic void model_reset();
    m_im = 0; m_ip = 0; m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0;
    m_exc = 0; m_epc = 0; m_count = 0; m_compare = 0;
  endfunction

  function automatic logic m_int_pend();
    return m_ie && !m_exl && ((m_ip & m_im) != 8'd0);
  endfunction

  function automatic logic m_intreq();
    if (reset) return 1'b0;
    return (m_int_pend() || (bus.nExc != 5'd0 && !m_exl)) && !bus.ERET;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return (32'(m_im) << 8) | (32'(m_exl) << 1) | 32'(m_ie);
      5'd13:   return (32'(m_bd) << 31) | (32'(m_ti) << 30) | (32'(m_ip) << 8) |
                      (32'(m_exc) << 2);
      5'd14:   return m_epc;
      5'd15:   return 32'h2020_1207;
      5'd9:    return m_count;
      5'd11:   return m_compare;
      default: return 32'd0;
    endcase
  endfunction

  function automatic void model_edge();
    logic        take, was_int, old_ti;
    logic [31:0] old_count, old_compare;
    was_int     = m_int_pend();
    take        = m_intreq();
    old_ti      = m_ti;
    old_count   = m_count;
    old_compare = m_compare;
    m_ip[7:2]   = {bus.HWInt[5] | old_ti, bus.HWInt[4:0]};
    m_count     = old_count + 1;
    if (old_count == old_compare) m_ti = 1'b1;
    if (take) begin
      m_exl = 1'b1;
      m_exc = was_int ? 5'd0 : bus.nExc;
      m_bd  = bus.nBD;
      m_epc = (bus.nBD ? bus.nEPC - 32'd4 : bus.nEPC) & 32'hFFFF_FFFC;
    end else if (bus.WE) begin
      case (bus.A2)
        5'd12: begin m_im = bus.WD[15:8]; m_exl = bus.WD[1]; m_ie = bus.WD[0]; end
        5'd13: m_ip[1:0] = bus.WD[9:8];
        5'd14: m_epc = bus.WD & 32'hFFFF_FFFC;
        5'd9:  m_count = bus.WD;
        5'd11: begin m_compare = bus.WD; m_ti = 1'b0; end
        default: ;
      endcase
    end
    if (bus.ERET) m_exl = 1'b0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic apply(input logic we, input logic [4:0] a2, input logic [31:0] wd,
                       input logic eret, input logic [4:0] nexc, input logic nbd,
                       input logic [31:0] nepc, input logic [5:0] hwint, input logic [4:0] a1);
    bus.WE = we; bus.A2 = a2; bus.WD = wd; bus.ERET = eret; bus.nExc = nexc;
    bus.nBD = nbd; bus.nEPC = nepc; bus.HWInt = hwint; bus.A1 = a1;
  endtask

  task automatic drv(input logic we, input logic [4:0] a2, input logic [31:0] wd,
                     input logic eret, input logic [4:0] nexc, input logic [4:0] a1);
    apply(we, a2, wd, eret, nexc, 1'b0, 32'd0, 6'd0, a1);
    #3;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else model_edge();
    #1;
  endtask

  initial begin
    logic [4:0] idx [8];
    idx = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd0, 5'd3};

    reset = 1'b1;
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      bus.A1 = idx[i];
      #1;
      check($sformatf("reset rd[%0d]", idx[i]), bus.RD,
            (idx[i] == 5'd15) ? 32'h2020_1207 : 32'd0);
    end
    bus.nExc = 5'd12;
    #1;
    check("reset intreq gated", 32'(bus.IntReq), 32'd0);
    bus.nExc = 5'd0;
    @(posedge clk);
    #1;
    reset = 1'b0;

    //          we a2     wd             er nexc  bd nepc           hw    a1     int exp_rd
    vecs[0]  = '{1'b1, 5'd11, 32'h1000_0000, 1'b0, 5'd0,  1'b0, 32'h0,         6'd0, 5'd12, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 5'd12, 32'h0000_0401, 1'b0, 5'd0,  1'b0, 32'h0,         6'd0, 5'd15, 1'b0, 32'h2020_1207};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  1'b0, 32'h0,         6'd1, 5'd12, 1'b0, 32'h0000_0401};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  1'b0, 32'h0000_1000, 6'd1, 5'd13, 1'b1, 32'h0000_0400};
    vecs[4]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  1'b0, 32'h0,         6'd1, 5'd12, 1'b0, 32'h0000_0403};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  1'b0, 32'h0,         6'd0, 5'd14, 1'b0, 32'h0000_1000};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd0,  1'b0, 32'h0,         6'd0, 5'd13, 1'b0, 32'h0};
    vecs[7]  = '{1'b1, 5'd14, 32'h0000_ABCC, 1'b0, 5'd12, 1'b1, 32'h0000_3014, 6'd0, 5'd12, 1'b1, 32'h0000_0401};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  1'b0, 32'h0,         6'd0, 5'd14, 1'b0, 32'h0000_3010};
    vecs[9]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  1'b0, 32'h0,         6'd0, 5'd13, 1'b0, 32'h8000_0030};
    vecs[10] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd12, 1'b0, 32'h0,         6'd0, 5'd12, 1'b0, 32'h0000_0403};
    vecs[11] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  1'b0, 32'h0,         6'd1, 5'd12, 1'b0, 32'h0000_0401};
    vecs[12] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd4,  1'b0, 32'h0000_2000, 6'd1, 5'd13, 1'b1, 32'h8000_0430};
    vecs[13] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  1'b0, 32'h0,         6'd1, 5'd13, 1'b0, 32'h0000_0400};
    vecs[14] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd0,  1'b0, 32'h0,         6'd1, 5'd14, 1'b0, 32'h0000_2000};
    vecs[15] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd0,  1'b0, 32'h0,         6'd1, 5'd12, 1'b0, 32'h0000_0401};
    vecs[16] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  1'b0, 32'h0000_2224, 6'd1, 5'd12, 1'b1, 32'h0000_0401};
    vecs[17] = '{1'b1, 5'd12, 32'h0000_0003, 1'b1, 5'd0,  1'b0, 32'h0,         6'd0, 5'd14, 1'b0, 32'h0000_2224};
    vecs[18] = '{1'b1, 5'd13, 32'h0000_0300, 1'b0, 5'd0,  1'b0, 32'h0,         6'd0, 5'd12, 1'b0, 32'h0000_0001};
    vecs[19] = '{1'b1, 5'd12, 32'h0000_0201, 1'b0, 5'd0,  1'b0, 32'h0,         6'd0, 5'd13, 1'b0, 32'h0000_0300};
    vecs[20] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  1'b0, 32'h0000_3000, 6'd0, 5'd12, 1'b1, 32'h0000_0201};
    vecs[21] = '{1'b1, 5'd15, 32'hFFFF_FFFF, 1'b0, 5'd0,  1'b0, 32'h0,         6'd0, 5'd15, 1'b0, 32'h2020_1207};
    vecs[22] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  1'b0, 32'h0,         6'd0, 5'd3,  1'b0, 32'h0};

    foreach (vecs[i]) begin
      apply(vecs[i].we, vecs[i].a2, vecs[i].wd, vecs[i].eret, vecs[i].nexc, vecs[i].nbd,
            vecs[i].nepc, vecs[i].hwint, vecs[i].a1);
      #3;
      check($sformatf("vec%0d intreq", i), 32'(bus.IntReq), 32'(vecs[i].exp_int));
      check($sformatf("vec%0d rd", i), bus.RD, vecs[i].exp_rd);
      tick();
    end

    // Count/Compare timer interrupt.
    drv(1, 5'd12, 32'h0, 1, 0, 5'd12); tick();
    drv(1, 5'd13, 32'h0, 0, 0, 5'd12); tick();
    drv(1, 5'd11, 32'd5, 0, 0, 5'd12); tick();
    drv(1, 5'd9,  32'd0, 0, 0, 5'd12); tick();
    drv(1, 5'd12, 32'h0000_8001, 0, 0, 5'd9);
    check("count after write", bus.RD, 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drv(0, 0, 0, 0, 0, 5'd9);
      tick();
    end
    drv(0, 0, 0, 0, 0, 5'd9);
    check("count reaches compare", bus.RD, 32'd5);
    check("no timer int yet", 32'(bus.IntReq), 32'd0);
    tick();
    drv(0, 0, 0, 0, 0, 5'd13);
    check("ti set", bus.RD, 32'h4000_0000);
    check("ip7 not yet", 32'(bus.IntReq), 32'd0);
    tick();
    drv(0, 0, 0, 0, 0, 5'd13);
    check("ti and ip7", bus.RD, 32'h4000_8000);
    check("timer intreq", 32'(bus.IntReq), 32'd1);
    tick();
    drv(1, 5'd11, 32'd100, 0, 0, 5'd13);
    check("nested blocked", 32'(bus.IntReq), 32'd0);
    tick();
    drv(0, 0, 0, 0, 0, 5'd13);
    check("ti cleared", bus.RD, 32'h0000_8000);
    tick();
    drv(0, 0, 0, 1, 0, 5'd13);
    check("ip7 cleared", bus.RD, 32'h0);
    tick();
    drv(0, 0, 0, 0, 0, 5'd12);
    check("sr after eret", bus.RD, 32'h0000_8001);
    check("no int after compare write", 32'(bus.IntReq), 32'd0);
    tick();

    // Count wraps.
    drv(1, 5'd9, 32'hFFFF_FFFF, 0, 0, 5'd9); tick();
    drv(0, 0, 0, 0, 0, 5'd9);
    check("count max", bus.RD, 32'hFFFF_FFFF);
    tick();
    drv(0, 0, 0, 0, 0, 5'd9);
    check("count wrap", bus.RD, 32'h0);
    tick();

    // Asynchronous reset in the middle of an exception.
    drv(0, 0, 0, 0, 5'd12, 5'd12);
    check("exc intreq", 32'(bus.IntReq), 32'd1);
    tick();
    drv(0, 0, 0, 0, 5'd12, 5'd12);
    check("exl set", bus.RD, 32'h0000_8003);
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    check("async reset sr", bus.RD, 32'h0);
    check("async reset intreq", 32'(bus.IntReq), 32'd0);
    bus.A1 = 5'd13;
    #1;
    check("async reset cause", bus.RD, 32'h0);
    tick();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic        we, eret, nbd;
      logic [4:0]  a1, a2, nexc;
      logic [31:0] wd;
      logic [4:0]  excs [4];
      excs = '{5'd4, 5'd5, 5'd10, 5'd12};
      we   = ($urandom_range(0, 2) == 0);
      a2   = idx[$urandom_range(0, 7)];
      wd   = $urandom;
      if (a2 == 5'd11 && $urandom_range(0, 1) == 1) wd = m_count + $urandom_range(2, 8);
      eret = ($urandom_range(0, 7) == 0);
      nexc = ($urandom_range(0, 5) == 0) ? excs[$urandom_range(0, 3)] : 5'd0;
      nbd  = 1'($urandom);
      a1   = idx[$urandom_range(0, 7)];
      apply(we, a2, wd, eret, nexc, nbd, $urandom, 6'($urandom), a1);
      #3;
      check("rand intreq", 32'(bus.IntReq), 32'(m_intreq()));
      check("rand rd", bus.RD, m_read(a1));
      check("rand epc", bus.EPC, m_epc);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
